vga_text_window: RTL

- Parametrised text-mode renderer that replaces the fixed single-row, 8-pixel character path in the VGA top level.
- Maps the timing generator's x/y into a rectangular character window.
- Fetches the character code from an external text RAM, then the glyph row from an external font ROM.
- Serialises glyph bits MSB-first into fg/bg colour, with hsync/vsync delayed to stay aligned with pixel data.

---
 rtl/vga_text_window_if.sv | 26 ++
 rtl/vga_text_window.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/vga_text_window_if.sv
// ---------------------------------------------------------------------------
// vga_text_window_if
// Memory-side bus between the text renderer and its external text RAM and
// font ROM. Both memories have one-cycle synchronous read latency.
//   char_addr  : text RAM address (row*COLS+col), driven by the renderer
//   char_code  : text RAM read data, valid one cycle after char_addr
//   glyph_addr : font ROM address {char_code, glyph_row}, driven by renderer
//   glyph_data : font ROM read data, valid one cycle after glyph_addr,
//                bit GLYPH_W-1 is the leftmost pixel
// Modports: master = renderer, slave = memories.
// ---------------------------------------------------------------------------
interface vga_text_window_if #(
  parameter int unsigned CHAR_AW  = 7,
  parameter int unsigned GLYPH_AW = 11,
  parameter int unsigned GLYPH_W  = 8
);
  logic [CHAR_AW-1:0]  char_addr;
  logic [7:0]          char_code;
  logic [GLYPH_AW-1:0] glyph_addr;
  logic [GLYPH_W-1:0]  glyph_data;

  modport master (output char_addr, output glyph_addr,
                  input  char_code, input  glyph_data);
  modport slave  (input  char_addr, input  glyph_addr,
                  output char_code, output glyph_data);
endinterface

// File: rtl/vga_text_window.sv
// ---------------------------------------------------------------------------
// vga_text_window
// Text-mode renderer: maps timing-generator x/y into a COLS x ROWS character
// window, fetches the character code from text RAM and the glyph row from
// font ROM, and serialises glyph bits MSB-first into fg/bg colour. Pixel data
// and syncs leave the block with a fixed latency of 3 clocks.
// Ports:
//   clk, rst          : pixel clock, asynchronous active-high reset
//   x_i, y_i          : current pixel column / line
//   valid_i           : visible-area flag
//   hsync_in_i/vsync_in_i : raw syncs
//   newframe_i        : one-cycle pulse at frame start (cursor blink only)
//   fg_color_i/bg_color_i : {R,G,B} colours, sampled at the output stage
//   mem               : text RAM / font ROM bus (master side)
//   r_o, g_o, b_o     : pixel colour, 0 outside the window or when blanked
//   hsync_o, vsync_o  : syncs delayed to match pixel data
// Optional feature: define VGA_TEXT_CURSOR_EN to add cursor_col_i /
// cursor_row_i and a 64-frame blinking inverted-cell cursor.
// ---------------------------------------------------------------------------
module vga_text_window #(
  parameter int unsigned GLYPH_W = 8,
  parameter int unsigned GLYPH_H = 8,
  parameter int unsigned COLS    = 32,
  parameter int unsigned ROWS    = 4,
  parameter int unsigned WIN_X0  = 64,
  parameter int unsigned WIN_Y0  = 300,
  parameter int unsigned COLOR_W = 1,
  localparam int unsigned COLW   = (COLS > 1) ? $clog2(COLS) : 1,
  localparam int unsigned TRW    = (ROWS > 1) ? $clog2(ROWS) : 1,
  localparam int unsigned CW     = 3 * COLOR_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [9:0]          x_i,
  input  logic [9:0]          y_i,
  input  logic                valid_i,
  input  logic                hsync_in_i,
  input  logic                vsync_in_i,
  input  logic                newframe_i,
  input  logic [CW-1:0]       fg_color_i,
  input  logic [CW-1:0]       bg_color_i,
`ifdef VGA_TEXT_CURSOR_EN
  input  logic [COLW-1:0]     cursor_col_i,
  input  logic [TRW-1:0]      cursor_row_i,
`endif
  vga_text_window_if.master   mem,
  output logic [COLOR_W-1:0]  r_o,
  output logic [COLOR_W-1:0]  g_o,
  output logic [COLOR_W-1:0]  b_o,
  output logic                hsync_o,
  output logic                vsync_o
);

  localparam int unsigned PXW     = (GLYPH_W > 1) ? $clog2(GLYPH_W) : 1;
  localparam int unsigned GHW     = $clog2(GLYPH_H);
  localparam int unsigned CAW     = $clog2(COLS * ROWS);
  localparam int unsigned X_END   = WIN_X0 + COLS * GLYPH_W;
  localparam int unsigned Y_END   = WIN_Y0 + ROWS * GLYPH_H;
  localparam bit          PX_POW2 = (GLYPH_W == (1 << PXW));

  // Elaboration-time parameter sanity checks
  if (X_END > 1024) begin : g_bad_x
    $error("vga_text_window: WIN_X0+COLS*GLYPH_W exceeds 1024");
  end
  if (Y_END > 1024) begin : g_bad_y
    $error("vga_text_window: WIN_Y0+ROWS*GLYPH_H exceeds 1024");
  end
  if (GLYPH_H < 2 || (GLYPH_H & (GLYPH_H - 1)) != 0) begin : g_bad_h
    $error("vga_text_window: GLYPH_H must be a power of 2 >= 2");
  end

  // S0 signals (combinational from x/y)
  logic            in_x, in_y, in_win_d;
  logic [9:0]      ry;
  logic [PXW-1:0]  px_d;
  logic [COLW-1:0] col_d;
  logic [TRW-1:0]  trow_d;
  logic [GHW-1:0]  grow_d;
  logic [CAW-1:0]  caddr_d;

  // S1 / S2 pipeline registers
  logic            s1_in_win_q, s2_in_win_q;
  logic [PXW-1:0]  s1_px_q, s2_px_q;
  logic [GHW-1:0]  s1_grow_q;
  logic            s1_hs_q, s1_vs_q, s2_hs_q, s2_vs_q;

  // Output stage
  logic [CW-1:0]   rgb_d, rgb_q;
  logic            hs_q, vs_q;
  logic            glyph_bit, cur_inv;

  // Window decision from unsigned compares only (no reliance on underflow)
  assign in_x     = ({1'b0, x_i} >= 11'(WIN_X0)) && ({1'b0, x_i} < 11'(X_END));
  assign in_y     = ({1'b0, y_i} >= 11'(WIN_Y0)) && ({1'b0, y_i} < 11'(Y_END));
  assign in_win_d = valid_i && in_x && in_y;

  assign ry     = y_i - 10'(WIN_Y0);
  assign trow_d = TRW'(ry >> GHW);
  assign grow_d = ry[GHW-1:0];

  if (PX_POW2) begin : g_px_shift
    // Power-of-2 glyph width: column and pixel fall out of the relative x
    logic [9:0] rx;
    assign rx    = x_i - 10'(WIN_X0);
    assign px_d  = rx[PXW-1:0];
    assign col_d = COLW'(rx >> PXW);
  end else begin : g_px_count
    // Non-power-of-2 width: cell counter that restarts at the window edge
    // and otherwise advances one pixel per clock.
    logic [PXW-1:0]  cell_px_q;
    logic [COLW-1:0] cell_col_q;

    always_comb begin
      px_d  = cell_px_q + PXW'(1);
      col_d = cell_col_q;
      if (x_i == 10'(WIN_X0)) begin
        px_d  = '0;
        col_d = '0;
      end else if (cell_px_q == PXW'(GLYPH_W - 1)) begin
        px_d  = '0;
        col_d = cell_col_q + COLW'(1);
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        cell_px_q  <= '0;
        cell_col_q <= '0;
      end else begin
        cell_px_q  <= px_d;
        cell_col_q <= col_d;
      end
    end
  end

  assign caddr_d = CAW'(trow_d) * CAW'(COLS) + CAW'(col_d);

  // Text RAM address; forced to 0 outside the window and during reset
  always_comb begin
    mem.char_addr = '0;
    if (!rst && in_win_d) mem.char_addr = caddr_d;
  end

  // Font ROM address from the returned character code and the S1 glyph row
  always_comb begin
    mem.glyph_addr = '0;
    if (s1_in_win_q) mem.glyph_addr = {mem.char_code, s1_grow_q};
  end

`ifdef VGA_TEXT_CURSOR_EN
  // Blinking cursor: frame counter bit 5 gives a 64-frame, 50% duty blink
  logic [5:0] frame_q, frame_d;
  logic       cur_d, s1_cur_q, s2_cur_q;

  assign frame_d = newframe_i ? frame_q + 6'd1 : frame_q;
  assign cur_d   = in_win_d && (trow_d == cursor_row_i) &&
                   (col_d == cursor_col_i) && !frame_q[5];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_q  <= '0;
      s1_cur_q <= 1'b0;
      s2_cur_q <= 1'b0;
    end else begin
      frame_q  <= frame_d;
      s1_cur_q <= cur_d;
      s2_cur_q <= s1_cur_q;
    end
  end

  assign cur_inv = s2_cur_q;
`else
  logic unused_newframe;
  assign unused_newframe = newframe_i;
  assign cur_inv         = 1'b0;
`endif

  // Pixel bit, MSB first
  assign glyph_bit = mem.glyph_data[PXW'(GLYPH_W - 1) - s2_px_q];

  // Output colour; colours are taken live so a change shows on the next pixel
  always_comb begin
    rgb_d = '0;
    if (s2_in_win_q) rgb_d = (glyph_bit ^ cur_inv) ? fg_color_i : bg_color_i;
  end

  // Pipeline: S0->S1, S1->S2, S2->output
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_in_win_q <= 1'b0;
      s1_px_q     <= '0;
      s1_grow_q   <= '0;
      s1_hs_q     <= 1'b0;
      s1_vs_q     <= 1'b0;
      s2_in_win_q <= 1'b0;
      s2_px_q     <= '0;
      s2_hs_q     <= 1'b0;
      s2_vs_q     <= 1'b0;
      rgb_q       <= '0;
      hs_q        <= 1'b0;
      vs_q        <= 1'b0;
    end else begin
      s1_in_win_q <= in_win_d;
      s1_px_q     <= px_d;
      s1_grow_q   <= grow_d;
      s1_hs_q     <= hsync_in_i;
      s1_vs_q     <= vsync_in_i;
      s2_in_win_q <= s1_in_win_q;
      s2_px_q     <= s1_px_q;
      s2_hs_q     <= s1_hs_q;
      s2_vs_q     <= s1_vs_q;
      rgb_q       <= rgb_d;
      hs_q        <= s2_hs_q;
      vs_q        <= s2_vs_q;
    end
  end

  assign r_o     = rgb_q[CW-1 -: COLOR_W];
  assign g_o     = rgb_q[2*COLOR_W-1 -: COLOR_W];
  assign b_o     = rgb_q[COLOR_W-1:0];
  assign hsync_o = hs_q;
  assign vsync_o = vs_q;

endmodule
